// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   The only module that drives the regfile write port (rd, RegWrite,
//   write_data3). It merges single-cycle ALU results with multi-cycle load
//   results. Loads wait in a small FIFO. A per-register busy scoreboard lets
//   decode detect load-use hazards. If the FIFO head keeps losing to the ALU,
//   it is eventually forced through by stalling the ALU for one cycle.
//
// Ports
//   clk, rst                 clock (rising edge); async active-low reset
//   alu_valid/rd/data        ALU result offered this cycle
//   alu_stall                ALU must hold its result (forced load slot)
//   load_valid/rd/data       load result offered; load_ready = FIFO not full
//   iss_valid/iss_rd         decode issues a load to iss_rd (marks it busy)
//   chk_rs1/chk_rs2, hazard  decode source check against the scoreboard
//   busy                     scoreboard, bit n = load pending to xn
//   err                      sticky: load issued to an already-busy register
//   rd/RegWrite/write_data3  regfile AD3/WE3/WD3
//
// Optional build macro WB_BYPASS_EN adds byp1_hit/byp1_data and
// byp2_hit/byp2_data. These forward the value being written this cycle to
// decode sources that would otherwise still read the old value.
module regfile_wb_arbiter #(
  parameter int A_WIDTH    = 5,
  parameter int D_WIDTH    = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [A_WIDTH-1:0]    alu_rd,
  input  logic [D_WIDTH-1:0]    alu_data,
  output logic                  alu_stall,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [A_WIDTH-1:0]    load_rd,
  input  logic [D_WIDTH-1:0]    load_data,
  input  logic                  iss_valid,
  input  logic [A_WIDTH-1:0]    iss_rd,
  input  logic [A_WIDTH-1:0]    chk_rs1,
  input  logic [A_WIDTH-1:0]    chk_rs2,
  output logic                  hazard,
  output logic [2**A_WIDTH-1:0] busy,
  output logic                  err,
  output logic [A_WIDTH-1:0]    rd,
  output logic                  RegWrite,
  output logic [D_WIDTH-1:0]    write_data3
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp1_hit,
  output logic [D_WIDTH-1:0]    byp1_data,
  output logic                  byp2_hit,
  output logic [D_WIDTH-1:0]    byp2_data
`endif
);

  localparam int NREG = 2**A_WIDTH;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [A_WIDTH-1:0] fifo_rd   [DEPTH];
  logic [D_WIDTH-1:0] fifo_data [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        occ;
  logic [CW-1:0]      starve_cnt;

  logic               fifo_empty, fifo_full;
  logic               push, pop, alu_win;
  logic [A_WIDTH-1:0] head_rd;
  logic [D_WIDTH-1:0] head_data;
  logic [NREG-1:0]    busy_set, busy_clr;
  logic               err_hit;

  logic               vld_p1;
  logic [A_WIDTH-1:0] rd_p1;
  logic [D_WIDTH-1:0] data_p1;

  // Stage p0: arbitration between the ALU result and the FIFO head.
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_CNT);
  assign load_ready = !fifo_full;
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // A starved head takes the port. The ALU is told to hold its result.
  assign alu_stall  = !fifo_empty && (starve_cnt == STARVE_LIM);
  // An ALU write to x0 is discarded, so it leaves the port free for a pop.
  assign alu_win    = alu_valid && (alu_rd != '0) && !alu_stall;
  assign pop        = !fifo_empty && !alu_win;
  // A load to x0 completes the handshake but is never queued.
  assign push       = load_valid && load_ready && (load_rd != '0);

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_valid && (iss_rd != '0)) busy_set[iss_rd] = 1'b1;
    if (pop)                         busy_clr[head_rd] = 1'b1;
  end

  // Re-issuing to a busy register is only legal if that load retires this cycle.
  assign err_hit = iss_valid && (iss_rd != '0) && busy[iss_rd] && !busy_clr[iss_rd];

  assign hazard = ((chk_rs1 != '0) && busy[chk_rs1]) ||
                  ((chk_rs2 != '0) && busy[chk_rs2]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= load_rd;
      fifo_data[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // A non-empty FIFO that does not pop has necessarily lost to the ALU.
      if (pop || fifo_empty) starve_cnt <= '0;
      else                   starve_cnt <= starve_cnt + 1'b1;
      busy <= (busy & ~busy_clr) | busy_set;
      if (err_hit) err <= 1'b1;
    end
  end

  // Stage p1: registered winner drives the regfile write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= alu_win || pop;
      if (alu_win) begin
        rd_p1   <= alu_rd;
        data_p1 <= alu_data;
      end else if (pop) begin
        rd_p1   <= head_rd;
        data_p1 <= head_data;
      end
    end
  end

  assign rd          = rd_p1;
  assign RegWrite    = vld_p1;
  assign write_data3 = data_p1;

`ifdef WB_BYPASS_EN
  assign byp1_hit  = vld_p1 && (rd_p1 == chk_rs1) && (chk_rs1 != '0);
  assign byp2_hit  = vld_p1 && (rd_p1 == chk_rs2) && (chk_rs2 != '0);
  assign byp1_data = byp1_hit ? data_p1 : '0;
  assign byp2_data = byp2_hit ? data_p1 : '0;
`endif

endmodule
